jk_updown_counter: RTL and testbench
====================================

JK_UPDOWN_COUNTER -- requirements
Module: jk_updown_counter

Interface
REQ-001 Parameter: WIDTH, 4, counter width in bits; legal range 2..8.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset; sampled on rising clk edge only.
REQ-004 Port: en  input  1  count enable; one step per cycle while high.
REQ-005 Port: up  input  1  direction: 1 = increment, 0 = decrement.
REQ-006 Port: load  input  1  synchronous parallel load of d.
REQ-007 Port: d  input  WIDTH  load value.
REQ-008 Port: max  input  WIDTH  programmable terminal value; count range 0..max.
REQ-009 Port: clr_ovf  input  1  clears sticky ovf flag.
REQ-010 Port: q  output  WIDTH  current count; registered.
REQ-011 Port: tc  output  1  combinational terminal-count indication.
REQ-012 Port: ovf  output  1  sticky wrap flag; registered.

Function
REQ-013 Priority per rising edge SHALL be: reset > load > en > hold.
REQ-014 load=1: q SHALL equal d after one edge, regardless of en, up, or max; values d > max are accepted unchanged.
REQ-015 en=1, up=1, load=0: next q SHALL be 0 if q >= max, else q+1.
REQ-016 en=1, up=0, load=0: next q SHALL be max if q == 0; else max if q > max; else q-1.
REQ-017 en=0, load=0: q SHALL hold.
REQ-018 max=0: counter SHALL stay at 0 under any counting, and every enabled step counts as a wrap.
REQ-019 tc SHALL be en & ~load & ((up & q >= max) | (~up & q == 0)), so it is high in exactly the cycle whose edge wraps.
REQ-020 ovf SHALL set on the edge where tc=1; clr_ovf SHALL clear it on the next edge; simultaneous tc and clr_ovf SHALL leave ovf=1 (set wins).
REQ-021 load or direction change mid-count SHALL take effect on the same edge, with no extra latency or skipped state.
REQ-022 Latency: q and ovf change one edge after qualifying inputs; tc has zero latency from q and inputs.
REQ-023 All arithmetic SHALL be WIDTH-bit modulo and unsigned; comparisons SHALL be unsigned.

Reset
REQ-024 reset=1 at a rising edge SHALL force q=0 and ovf=0, overriding load, en and clr_ovf.
REQ-025 tc SHALL follow REQ-019 during reset; it is not forced low.
REQ-026 Reset asserted mid-count SHALL abort counting at the next edge, and counting SHALL resume from 0 on the first edge after release.
REQ-027 No asynchronous path from reset to any state element SHALL exist.

Structure
REQ-028 Each bit of q SHALL be held by one JK_Flipflop instance, clocked by clk and reset by reset; no other storage SHALL be used for q.
REQ-029 The next-state value nxt SHALL be computed combinationally per REQ-013..018, and each bit SHALL be driven as J_i = nxt_i, K_i = ~nxt_i.
REQ-030 ovf MAY use a single D_Flipflop instance or an equivalent synchronous-reset register.
REQ-031 WIDTH limits and the reset value (0) SHALL live in the shared counter package; no typedefs are needed.
REQ-032 The only sub-module SHALL be JK_Flipflop (plus optional D_Flipflop for ovf), generated per bit.

Verification (WIDTH=4)
REQ-033 Apply reset, then max=9, up=1, en=1 for 12 cycles -> q = 1..9, 0, 1, 2; tc high only when q=9; ovf=1 from the edge after q=9.
REQ-034 From q=0, max=5, up=0, en=1 -> q = 5, 4, 3 …; tc=1 in the q=0 cycle; ovf sets.
REQ-035 Load d=12 with max=9, then count up 1 cycle -> q=12, then 0, with tc=1 while q=12; count down from q=12 -> q=9.
REQ-036 Assert load=1, d=7, en=1, up=1 together at q=3 -> q=7, with no increment that cycle.
REQ-037 Assert tc and clr_ovf on the same edge -> ovf stays 1; clr_ovf alone on a later edge -> ovf=0.
REQ-038 Assert reset at q=6 together with load=1 and d=2 -> q=0 and ovf=0; after release with en=1, up=1 -> q=1.

Source files
------------

// File: rtl/jk_updown_counter_pkg.sv
// Shared constants for the JK up/down counter: legal width range and reset value.
package jk_updown_counter_pkg;

    localparam int WIDTH_MIN   = 2;
    localparam int WIDTH_MAX   = 8;
    localparam int RESET_VALUE = 0;

endpackage

// File: rtl/jk_updown_counter_jk_flipflop.sv
// Single-bit JK flip-flop with synchronous active-high reset.
module JK_Flipflop
    import jk_updown_counter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q
);

    logic state_q;
    logic state_d;

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case ({j, k})
            2'b10:   state_d = 1'b1;
            2'b01:   state_d = 1'b0;
            2'b11:   state_d = ~state_q;
            default: state_d = state_q;
        endcase
    end

    // NOTE: non-blocking assignment for flop state avoids simulation ordering races.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RESET_VALUE[0];
        end else begin
            state_q <= state_d;
        end
    end

    assign q = state_q;

endmodule

// File: rtl/jk_updown_counter.sv
// Programmable-modulus up/down counter built from per-bit JK flip-flops, with sticky wrap flag.
module jk_updown_counter
    import jk_updown_counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] max,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
        $error("jk_updown_counter: WIDTH %0d outside legal range", WIDTH);
    end

    logic [WIDTH-1:0] cnt_d;
    logic             ovf_q;
    logic             ovf_d;

    // tc marks exactly the cycle whose edge wraps the count.
    assign tc = en & ~load & ((up & (q >= max)) | (~up & (q == '0)));

    always_comb begin
        cnt_d = q;
        if (load) begin
            cnt_d = d;
        end else if (en) begin
            if (up) begin
                cnt_d = (q >= max) ? '0 : q + WIDTH'(1);
            end else begin
                cnt_d = ((q == '0) || (q > max)) ? max : q - WIDTH'(1);
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        JK_Flipflop u_jk (
            .clk   (clk),
            .reset (reset),
            .j     (cnt_d[i]),
            .k     (~cnt_d[i]),
            .q     (q[i])
        );
    end

    // Set wins over clear when a wrap and clr_ovf coincide.
    always_comb begin
        ovf_d = ovf_q;
        if (tc) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;

endmodule

// File: tb/tb_jk_updown_counter.sv
// Self-checking bench: directed scenarios plus random stimulus against an integer reference model.
module tb_jk_updown_counter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic         up;
    logic         load;
    logic [W-1:0] d;
    logic [W-1:0] max;
    logic         clr_ovf;
    logic [W-1:0] q;
    logic         tc;
    logic         ovf;

    int errors = 0;
    int checks = 0;
    int mq     = 0;
    int movf   = 0;

    jk_updown_counter #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .up      (up),
        .load    (load),
        .d       (d),
        .max     (max),
        .clr_ovf (clr_ovf),
        .q       (q),
        .tc      (tc),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check tc before the edge, check q/ovf after it.
    task automatic step(input logic r, input logic l, input logic e, input logic u,
                        input int dv, input int mv, input logic c);
        logic exp_tc;
        @(negedge clk);
        reset   = r;
        load    = l;
        en      = e;
        up      = u;
        d       = W'(dv);
        max     = W'(mv);
        clr_ovf = c;
        #1;
        exp_tc = e && !l && ((u && mq >= mv) || (!u && mq == 0));
        check("tc", 32'(tc), 32'(exp_tc));
        @(posedge clk);
        if (r) begin
            mq   = 0;
            movf = 0;
        end else begin
            if (exp_tc)  movf = 1;
            else if (c)  movf = 0;
            if (l)       mq = dv;
            else if (e) begin
                if (u) mq = (mq >= mv) ? 0 : mq + 1;
                else   mq = (mq == 0 || mq > mv) ? mv : mq - 1;
            end
        end
        #1;
        check("q", 32'(q), 32'(mq));
        check("ovf", 32'(ovf), 32'(movf));
    endtask

    initial begin
        int up_seq[12];
        up_seq = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};

        // Reset state
        step(1, 0, 0, 1, 0, 9, 0);
        check("reset_q", 32'(q), 32'd0);
        check("reset_ovf", 32'(ovf), 32'd0);

        // Count up through a wrap with max=9
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 1, 1, 0, 9, 0);
            check("up_seq", 32'(q), 32'(up_seq[i]));
        end
        check("ovf_after_wrap", 32'(ovf), 32'd1);

        // Wrap coinciding with clr_ovf keeps ovf set; later clr_ovf alone clears it
        step(0, 1, 0, 1, 9, 9, 0);
        step(0, 0, 1, 1, 0, 9, 1);
        check("set_wins_q", 32'(q), 32'd0);
        check("set_wins_ovf", 32'(ovf), 32'd1);
        step(0, 0, 0, 1, 0, 9, 1);
        check("clr_ovf", 32'(ovf), 32'd0);

        // Count down from 0 with max=5
        step(1, 0, 0, 0, 0, 5, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 0, 0, 5, 0);
            check("down_seq", 32'(q), 32'(5 - i));
        end
        check("down_ovf", 32'(ovf), 32'd1);

        // Load above max, then wrap up / clamp down
        step(0, 1, 1, 1, 12, 9, 1);
        check("load12", 32'(q), 32'd12);
        step(0, 0, 1, 1, 0, 9, 0);
        check("up_from_12", 32'(q), 32'd0);
        step(0, 1, 0, 1, 12, 9, 0);
        step(0, 0, 1, 0, 0, 9, 0);
        check("down_from_12", 32'(q), 32'd9);

        // Load beats enable
        step(0, 1, 0, 1, 3, 9, 0);
        step(0, 1, 1, 1, 7, 9, 0);
        check("load_over_en", 32'(q), 32'd7);

        // Reset beats load mid-count, then counting resumes from 0
        step(0, 1, 0, 1, 6, 9, 0);
        step(1, 1, 1, 1, 2, 9, 0);
        check("reset_over_load", 32'(q), 32'd0);
        step(0, 0, 1, 1, 0, 9, 0);
        check("resume", 32'(q), 32'd1);

        // max=0: stays at 0, every enabled step wraps
        step(0, 0, 1, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        check("max0_q", 32'(q), 32'd0);
        check("max0_ovf", 32'(ovf), 32'd1);

        // Random stimulus
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) != 0),
                 1'($urandom),
                 int'($urandom_range(0, 15)),
                 ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 15)) : 9,
                 ($urandom_range(0, 7) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
